// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard controller for the 5-stage RISC-V core.
// Forwarding, load-use and legacy RAW stalls, branch flushes, MC wait, mem freeze.
module riscv_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int MC_MAX = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_rs1_i,
    input  logic [REG_AW-1:0] ID_rs2_i,
    input  logic              ID_rs1_use_i,
    input  logic              ID_rs2_use_i,
    input  logic [REG_AW-1:0] EX_rs1_i,
    input  logic [REG_AW-1:0] EX_rs2_i,
    input  logic [REG_AW-1:0] EX_rd_i,
    input  logic              EX_RegWr_en,
    input  logic              EX_MemRd_i,
    input  logic [REG_AW-1:0] MEM_rd_i,
    input  logic              MEM_RegWr_en,
    input  logic [REG_AW-1:0] WB_rd_i,
    input  logic              WB_RegWr_en,
    input  logic              EX_branch_taken_i,
    input  logic              EX_mc_start_i,
    input  logic              EX_mc_done_i,
    input  logic              MEM_busy_i,
    input  logic              cnt_clr_i,
    output logic              PC_stall_o,
    output logic              IFID_stall_o,
    output logic              IDEX_stall_o,
    output logic              EXMEM_stall_o,
    output logic              WB_stall_o,
    output logic              IFID_flush_o,
    output logic              IDEX_flush_o,
    output logic              EXMEM_flush_o,
    output logic              WB_flush_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              mc_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int MCW = (MC_MAX < 2) ? 1 : $clog2(MC_MAX);
    localparam logic [MCW-1:0] LAST = MCW'(MC_MAX - 1);

    typedef enum logic {ST_RUN, ST_MC_WAIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MCW-1:0]   r_mc_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_mem_a, w_mem_b, w_wb_a, w_wb_b;
    logic w_id_ex, w_id_mem, w_id_wb;
    logic w_ld_use, w_raw;
    logic w_mc_enter, w_mc_stall, w_mc_last;

    // Hazard detection terms; x0 and non-writing stages never match
    always_comb begin
        w_mem_a  = MEM_RegWr_en && (MEM_rd_i != '0) && (MEM_rd_i == EX_rs1_i);
        w_mem_b  = MEM_RegWr_en && (MEM_rd_i != '0) && (MEM_rd_i == EX_rs2_i);
        w_wb_a   = WB_RegWr_en && (WB_rd_i != '0) && (WB_rd_i == EX_rs1_i);
        w_wb_b   = WB_RegWr_en && (WB_rd_i != '0) && (WB_rd_i == EX_rs2_i);
        w_id_ex  = EX_RegWr_en && (EX_rd_i != '0) &&
                   ((ID_rs1_use_i && (ID_rs1_i == EX_rd_i)) ||
                    (ID_rs2_use_i && (ID_rs2_i == EX_rd_i)));
        w_id_mem = MEM_RegWr_en && (MEM_rd_i != '0) &&
                   ((ID_rs1_use_i && (ID_rs1_i == MEM_rd_i)) ||
                    (ID_rs2_use_i && (ID_rs2_i == MEM_rd_i)));
        w_id_wb  = WB_RegWr_en && (WB_rd_i != '0) &&
                   ((ID_rs1_use_i && (ID_rs1_i == WB_rd_i)) ||
                    (ID_rs2_use_i && (ID_rs2_i == WB_rd_i)));
        w_ld_use = (FWD_EN != 0) && EX_MemRd_i && w_id_ex;
        w_raw    = (FWD_EN == 0) && (w_id_ex || w_id_mem || w_id_wb);
        w_mc_enter = (r_state == ST_RUN) && EX_mc_start_i && !EX_mc_done_i;
        w_mc_last  = (r_state == ST_MC_WAIT) && !EX_mc_done_i &&
                     (r_mc_cnt == LAST);
        w_mc_stall = w_mc_enter ||
                     ((r_state == ST_MC_WAIT) && !EX_mc_done_i);
    end

    // Prioritised stall/flush/forward outputs, all forced low in reset
    always_comb begin
        PC_stall_o    = 1'b0;
        IFID_stall_o  = 1'b0;
        IDEX_stall_o  = 1'b0;
        EXMEM_stall_o = 1'b0;
        WB_stall_o    = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        EXMEM_flush_o = 1'b0;
        WB_flush_o    = 1'b0;
        fwd_a_sel_o   = 2'b00;
        fwd_b_sel_o   = 2'b00;
        if (!rst_i) begin
            if (FWD_EN != 0) begin
                fwd_a_sel_o = w_mem_a ? 2'b01 : (w_wb_a ? 2'b10 : 2'b00);
                fwd_b_sel_o = w_mem_b ? 2'b01 : (w_wb_b ? 2'b10 : 2'b00);
            end
            if (MEM_busy_i) begin
                PC_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_stall_o  = 1'b1;
                EXMEM_stall_o = 1'b1;
                WB_flush_o    = 1'b1;
            end else if (w_mc_stall) begin
                PC_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_stall_o  = 1'b1;
                EXMEM_flush_o = 1'b1;
            end else if (EX_branch_taken_i) begin
                IFID_flush_o  = 1'b1;
                IDEX_flush_o  = 1'b1;
            end else if (w_ld_use || w_raw) begin
                PC_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_flush_o  = 1'b1;
            end
        end
    end

    // Next state; a data-memory stall freezes the FSM
    always_comb begin
        w_state_nxt = r_state;
        if (!MEM_busy_i) begin
            if (r_state == ST_RUN) begin
                if (w_mc_enter) w_state_nxt = ST_MC_WAIT;
            end else if (EX_mc_done_i || w_mc_last) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // State, wait counter and timeout pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_mc_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= !MEM_busy_i && w_mc_last;
            if (!MEM_busy_i) begin
                if (w_mc_enter)
                    r_mc_cnt <= '0;
                else if (w_mc_stall && !w_mc_last)
                    r_mc_cnt <= r_mc_cnt + MCW'(1);
            end
        end
    end

    // Saturating count of PC-stall cycles; clear wins over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (cnt_clr_i)
            r_stall_cnt <= '0;
        else if (PC_stall_o && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign mc_timeout_o = r_timeout;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed self-checking bench for riscv_hazard_unit.
// Instance A: forwarding, MC_MAX=4, CNT_W=4. Instance B: legacy, MC_MAX=8.
module tb_riscv_hazard_unit;

    localparam logic [8:0] SF_NONE = 9'b00000_0000;
    localparam logic [8:0] SF_LU   = 9'b11000_0100;
    localparam logic [8:0] SF_BR   = 9'b00000_1100;
    localparam logic [8:0] SF_MC   = 9'b11100_0010;
    localparam logic [8:0] SF_BUSY = 9'b11110_0001;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_u1, id_u2, ex_wr, ex_ld, mem_wr, wb_wr;
    logic       br, mc_start, mc_done, busy, clr;

    logic [8:0]  a_sf, b_sf;
    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_to, b_to;
    logic [3:0]  a_cnt;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    riscv_hazard_unit #(.REG_AW(5), .FWD_EN(1), .MC_MAX(4), .CNT_W(4)) u_a (
        .clk_i(clk), .rst_i(rst),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
        .ID_rs1_use_i(id_u1), .ID_rs2_use_i(id_u2),
        .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_rd_i(ex_rd),
        .EX_RegWr_en(ex_wr), .EX_MemRd_i(ex_ld),
        .MEM_rd_i(mem_rd), .MEM_RegWr_en(mem_wr),
        .WB_rd_i(wb_rd), .WB_RegWr_en(wb_wr),
        .EX_branch_taken_i(br), .EX_mc_start_i(mc_start),
        .EX_mc_done_i(mc_done), .MEM_busy_i(busy), .cnt_clr_i(clr),
        .PC_stall_o(a_sf[8]), .IFID_stall_o(a_sf[7]),
        .IDEX_stall_o(a_sf[6]), .EXMEM_stall_o(a_sf[5]),
        .WB_stall_o(a_sf[4]), .IFID_flush_o(a_sf[3]),
        .IDEX_flush_o(a_sf[2]), .EXMEM_flush_o(a_sf[1]),
        .WB_flush_o(a_sf[0]),
        .fwd_a_sel_o(a_fa), .fwd_b_sel_o(a_fb),
        .mc_timeout_o(a_to), .stall_cnt_o(a_cnt)
    );

    riscv_hazard_unit #(.REG_AW(5), .FWD_EN(0), .MC_MAX(8), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
        .ID_rs1_use_i(id_u1), .ID_rs2_use_i(id_u2),
        .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_rd_i(ex_rd),
        .EX_RegWr_en(ex_wr), .EX_MemRd_i(ex_ld),
        .MEM_rd_i(mem_rd), .MEM_RegWr_en(mem_wr),
        .WB_rd_i(wb_rd), .WB_RegWr_en(wb_wr),
        .EX_branch_taken_i(br), .EX_mc_start_i(mc_start),
        .EX_mc_done_i(mc_done), .MEM_busy_i(busy), .cnt_clr_i(clr),
        .PC_stall_o(b_sf[8]), .IFID_stall_o(b_sf[7]),
        .IDEX_stall_o(b_sf[6]), .EXMEM_stall_o(b_sf[5]),
        .WB_stall_o(b_sf[4]), .IFID_flush_o(b_sf[3]),
        .IDEX_flush_o(b_sf[2]), .EXMEM_flush_o(b_sf[1]),
        .WB_flush_o(b_sf[0]),
        .fwd_a_sel_o(b_fa), .fwd_b_sel_o(b_fb),
        .mc_timeout_o(b_to), .stall_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_u1 = 0; id_u2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wr = 0; ex_ld = 0;
        mem_rd = 0; mem_wr = 0; wb_rd = 0; wb_wr = 0;
        br = 0; mc_start = 0; mc_done = 0; busy = 0; clr = 0;
    endtask

    task automatic load_use();
        ex_ld = 1; ex_rd = 5; ex_wr = 1; id_rs2 = 5; id_u2 = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        load_use();
        #2;
        chk("rst_sf", a_sf, SF_NONE);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_to", a_to, 0);
        cyc(); idle(); cyc();
        rst = 0;

        // forwarding priority and x0
        cyc();
        ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 3;
        mem_wr = 1; wb_wr = 1;
        #1;
        chk("fwd_a_mem", a_fa, 2'b01);
        chk("fwd_b_mem", a_fb, 2'b01);
        chk("fwd_legacy", b_fa, 2'b00);
        chk("fwd_nostall", a_sf, SF_NONE);
        cyc(); mem_wr = 0; #1;
        chk("fwd_a_wb", a_fa, 2'b10);
        cyc(); mem_wr = 1; mem_rd = 0; wb_rd = 0; #1;
        chk("fwd_a_x0", a_fa, 2'b00);

        // load-use: one bubble, then forwarding covers it
        cyc(); idle(); load_use(); #1;
        chk("lu_sf", a_sf, SF_LU);
        cyc();
        ex_ld = 0; ex_rd = 0; ex_wr = 0; mem_rd = 5; mem_wr = 1; #1;
        chk("lu_after", a_sf, SF_NONE);
        chk("lu_cnt", a_cnt, 1);
        cyc(); idle(); load_use(); br = 1; #1;
        chk("lu_branch", a_sf, SF_BR);

        // legacy RAW against WB, and x0 never hazards
        cyc(); idle(); wb_rd = 7; wb_wr = 1; id_rs1 = 7; id_u1 = 1; #1;
        chk("raw_legacy", b_sf, SF_LU);
        chk("raw_fwdmode", a_sf, SF_NONE);
        cyc(); wb_rd = 0; id_rs1 = 0; #1;
        chk("raw_x0", b_sf, SF_NONE);

        // counter clear
        cyc(); idle(); clr = 1;
        cyc(); clr = 0; #1;
        chk("clr_cnt", a_cnt, 0);

        // B: done on 4th wait cycle -> 4 stall cycles
        cyc(); mc_start = 1; #1;
        chk("mc_start", b_sf, SF_MC);
        cyc(); mc_start = 0; #1;
        chk("mc_w1", b_sf, SF_MC);
        cyc(); #1; chk("mc_w2", b_sf, SF_MC);
        cyc(); #1; chk("mc_w3", b_sf, SF_MC);
        cyc(); mc_done = 1; #1;
        chk("mc_done", b_sf, SF_NONE);
        cyc(); mc_done = 0; #1;
        chk("mc_run", b_sf, SF_NONE);
        chk("mc_noto", b_to, 0);
        cyc(); mc_start = 1; mc_done = 1; #1;
        chk("mc_same", b_sf, SF_NONE);
        cyc(); mc_start = 0; mc_done = 0; #1;
        chk("mc_same_run", b_sf, SF_NONE);

        // A: timeout after 1 + 4 stall cycles
        cyc(); clr = 1;
        cyc(); clr = 0; mc_start = 1; #1;
        chk("to_s", a_sf, SF_MC);
        cyc(); mc_start = 0; #1; chk("to_w1", a_sf, SF_MC);
        cyc(); #1; chk("to_w2", a_sf, SF_MC);
        cyc(); #1; chk("to_w3", a_sf, SF_MC);
        cyc(); #1; chk("to_w4", a_sf, SF_MC);
        chk("to_w4_pulse", a_to, 0);
        cyc(); #1;
        chk("to_run", a_sf, SF_NONE);
        chk("to_pulse", a_to, 1);
        chk("to_cnt", a_cnt, 5);
        cyc(); #1;
        chk("to_pulse_end", a_to, 0);

        // A: 3 busy cycles inside MC_WAIT extend the timeout by 3
        cyc(); mc_start = 1; #1; chk("bz_s", a_sf, SF_MC);
        cyc(); mc_start = 0; #1; chk("bz_w1", a_sf, SF_MC);
        cyc(); #1; chk("bz_w2", a_sf, SF_MC);
        cyc(); busy = 1; #1; chk("bz_f1", a_sf, SF_BUSY);
        cyc(); #1; chk("bz_f2", a_sf, SF_BUSY);
        cyc(); #1; chk("bz_f3", a_sf, SF_BUSY);
        cyc(); busy = 0; #1; chk("bz_w3", a_sf, SF_MC);
        cyc(); #1; chk("bz_w4", a_sf, SF_MC);
        chk("bz_w4_pulse", a_to, 0);
        cyc(); #1;
        chk("bz_run", a_sf, SF_NONE);
        chk("bz_pulse", a_to, 1);

        // saturation at CNT_W=4 and clear priority
        cyc(); clr = 1;
        cyc(); clr = 0; load_use();
        for (int i = 0; i < 20; i++) cyc();
        idle(); #1;
        chk("sat_cnt", a_cnt, 4'hF);
        cyc(); load_use(); clr = 1;
        cyc(); idle(); #1;
        chk("sat_clr", a_cnt, 0);

        // async reset mid MC_WAIT
        cyc(); mc_start = 1;
        cyc(); mc_start = 0; ex_rs1 = 3; mem_rd = 3; mem_wr = 1; #1;
        chk("ar_wait", a_sf, SF_MC);
        chk("ar_fwd_pre", a_fa, 2'b01);
        #1; rst = 1; #1;
        chk("ar_sf", a_sf, SF_NONE);
        chk("ar_fwd", a_fa, 2'b00);
        chk("ar_cnt", a_cnt, 0);
        chk("ar_to", a_to, 0);
        cyc(); idle(); rst = 0;
        cyc(); #1;
        chk("ar_run", a_sf, SF_NONE);
        chk("ar_no_pulse", a_to, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
